// File: rtl/flappy_pkg.sv
// Shared constants for the flappy game: screen and bird geometry, the pipe
// gap table and the game-flow state encoding.
package flappy_pkg;

    // Screen geometry, 11 bits so sums with 10-bit coordinates never truncate.
    localparam logic [10:0] SCREEN_W = 11'd640;
    localparam logic [10:0] SCREEN_H = 11'd480;

    // Bird window: fixed horizontal span, variable top edge.
    localparam logic [10:0] BIRD_X_L = 11'd300;
    localparam logic [10:0] BIRD_X_R = 11'd320;
    localparam logic [10:0] BIRD_H   = 11'd20;

    // Vertical opening of every pipe.
    localparam logic [10:0] GAP_H = 11'd120;

    // Frames frozen after a hit before game-over.
    localparam int HIT_HOLD_DEF = 30;

    // Top of the opening for each of the four pipes, indexed by pipe number.
    localparam logic [3:0][9:0] GAP_TABLE = {10'd260, 10'd60, 10'd200, 10'd100};

    // One-hot game-flow states; the bit positions double as the state flags.
    typedef logic [3:0] state_t;
    localparam int     IDLE_BIT = 0;
    localparam int     RUN_BIT  = 1;
    localparam int     HIT_BIT  = 2;
    localparam int     OVER_BIT = 3;
    localparam state_t ST_IDLE  = 4'b0001;
    localparam state_t ST_RUN   = 4'b0010;
    localparam state_t ST_HIT   = 4'b0100;
    localparam state_t ST_OVER  = 4'b1000;

endpackage

// File: rtl/gap_rom.sv
// Pipe gap lookup: maps a 2-bit pipe index to the top line of its opening.
// Purely combinational so the renderer and the collision check see the same
// value in the same cycle.
module gap_rom
    import flappy_pkg::*;
(
    input  logic [1:0] pipe_idx_i,
    output logic [9:0] gap_top_o
);

    // Case table over the four pipes.
    // NOTE: every path assigns gap_top_o (default first), so no latch is inferred.
    always_comb begin
        gap_top_o = GAP_TABLE[0];
        case (pipe_idx_i)
            2'd0:    gap_top_o = GAP_TABLE[0];
            2'd1:    gap_top_o = GAP_TABLE[1];
            2'd2:    gap_top_o = GAP_TABLE[2];
            2'd3:    gap_top_o = GAP_TABLE[3];
            default: gap_top_o = GAP_TABLE[0];
        endcase
    end

endmodule

// File: rtl/pipe_collision_ctrl.sv
// Game-flow controller and collision detector. Answers the pipe scroller's
// Start/Stop/Ack handshake, checks the bird against the in-scope pipe and the
// screen bounds once per frame, holds the game frozen for a number of frames
// after a hit and tracks the best score since reset.
module pipe_collision_ctrl
    import flappy_pkg::*;
#(
    parameter int HIT_HOLD = HIT_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       btn_ack,
    input  logic [9:0] x_left,
    input  logic [9:0] x_right,
    input  logic [1:0] pipe_idx,
    input  logic [9:0] bird_y,
    input  logic [3:0] score,
    output logic       start,
    output logic       stop,
    output logic       ack,
    output logic [9:0] gap_top,
    output logic [3:0] high_score,
    output logic       q_idle,
    output logic       q_run,
    output logic       q_hit,
    output logic       q_over
);

    // Hold counter is at least 5 bits and grows with HIT_HOLD.
    localparam int                CNT_W     = ($clog2(HIT_HOLD) > 5) ? $clog2(HIT_HOLD) : 5;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HIT_HOLD - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         high_q, high_d;
    logic               start_q, start_d;
    logic               stop_q, stop_d;
    logic               ack_q, ack_d;

    logic [10:0]        bird_bot;
    logic [10:0]        gap_bot;
    logic               h_hit, v_miss, bound, collide;

    gap_rom u_gap_rom (
        .pipe_idx_i (pipe_idx),
        .gap_top_o  (gap_top)
    );

    // Collision geometry, all sums in 11 bits so no edge wraps.
    always_comb begin
        bird_bot = {1'b0, bird_y} + BIRD_H;
        gap_bot  = {1'b0, gap_top} + GAP_H;
        h_hit    = ({1'b0, x_left} <= BIRD_X_R) && ({1'b0, x_right} >= BIRD_X_L);
        v_miss   = (bird_y < gap_top) || (bird_bot > gap_bot);
        bound    = (bird_y == 10'd0) || (bird_bot >= SCREEN_H);
        collide  = (h_hit && v_miss) || bound;
    end

    // Next-state logic for the game flow, hold counter, high score and handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        high_d  = high_q;
        start_d = 1'b0;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_start) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                end
            end
            ST_RUN: begin
                // A tick landing on the IDLE->RUN edge was seen in IDLE, so the
                // first evaluation is always on the following tick.
                if (frame_tick && collide) begin
                    state_d = ST_HIT;
                    cnt_d   = '0;
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_OVER;
                        if (score > high_q) begin
                            high_d = score;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (btn_ack) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Stop follows the state being entered, so it rises with HIT and
        // drops on the same edge that leaves OVER.
        stop_d = (state_d == ST_HIT) || (state_d == ST_OVER);
    end

    // State, counter, score and handshake registers with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            high_q  <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            high_q  <= high_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            ack_q   <= ack_d;
        end
    end

    assign start      = start_q;
    assign stop       = stop_q;
    assign ack        = ack_q;
    assign high_score = high_q;
    assign q_idle     = state_q[IDLE_BIT];
    assign q_run      = state_q[RUN_BIT];
    assign q_hit      = state_q[HIT_BIT];
    assign q_over     = state_q[OVER_BIT];

endmodule

// File: tb/tb_pipe_collision_ctrl.sv
// Directed bench for pipe_collision_ctrl. Expected outputs are queued when a
// step is driven and compared when the DUT has produced them.
module tb_pipe_collision_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick, btn_start, btn_ack;
    logic [9:0] x_left, x_right, bird_y;
    logic [1:0] pipe_idx;
    logic [3:0] score;
    logic       start, stop, ack;
    logic [9:0] gap_top;
    logic [3:0] high_score;
    logic       q_idle, q_run, q_hit, q_over;

    int checks = 0;
    int errors = 0;

    // Output flag vector: {start, stop, ack, q_idle, q_run, q_hit, q_over}
    localparam logic [6:0] F_IDLE  = 7'b0001000;
    localparam logic [6:0] F_RUN   = 7'b0000100;
    localparam logic [6:0] F_START = 7'b1000100;
    localparam logic [6:0] F_HIT   = 7'b0100010;
    localparam logic [6:0] F_OVER  = 7'b0100001;
    localparam logic [6:0] F_ACK   = 7'b0011000;

    typedef struct {
        string      tag;
        logic [6:0] flags;
        logic [3:0] hs;
        logic [9:0] gap;
    } exp_t;

    exp_t exp_q[$];

    pipe_collision_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
        .btn_ack    (btn_ack),
        .x_left     (x_left),
        .x_right    (x_right),
        .pipe_idx   (pipe_idx),
        .bird_y     (bird_y),
        .score      (score),
        .start      (start),
        .stop       (stop),
        .ack        (ack),
        .gap_top    (gap_top),
        .high_score (high_score),
        .q_idle     (q_idle),
        .q_run      (q_run),
        .q_hit      (q_hit),
        .q_over     (q_over)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] gap_ref(input logic [1:0] i);
        case (i)
            2'd0:    return 10'd100;
            2'd1:    return 10'd200;
            2'd2:    return 10'd60;
            default: return 10'd260;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [6:0] f, input logic [3:0] hs);
        exp_t e;
        e.tag   = tag;
        e.flags = f;
        e.hs    = hs;
        e.gap   = gap_ref(pipe_idx);
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, " flags"}, 32'({start, stop, ack, q_idle, q_run, q_hit, q_over}), 32'(e.flags));
        check({e.tag, " high_score"}, 32'(high_score), 32'(e.hs));
        check({e.tag, " gap_top"}, 32'(gap_top), 32'(e.gap));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one clock edge and compare what the DUT shows after it.
    task automatic step(input string tag, input logic [6:0] f, input logic [3:0] hs);
        push(tag, f, hs);
        cycle();
        pop_check();
    endtask

    // Compare without a clock edge (combinational or asynchronous effects).
    task automatic now(input string tag, input logic [6:0] f, input logic [3:0] hs);
        push(tag, f, hs);
        #1;
        pop_check();
    endtask

    // Run the HIT hold: 29 ticks stay in HIT, the 30th enters OVER.
    task automatic hold_to_over(input string tag, input logic [3:0] hs_before, input logic [3:0] hs_after);
        frame_tick = 1'b1;
        for (int i = 0; i < 29; i++) cycle();
        now({tag, " 29 ticks"}, F_HIT, hs_before);
        step({tag, " 30th tick"}, F_OVER, hs_after);
        frame_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; btn_start = 1'b0; btn_ack = 1'b0;
        x_left = 10'd600; x_right = 10'd639; bird_y = 10'd150;
        pipe_idx = 2'd0; score = 4'd0;
        #12;
        now("reset", F_IDLE, 4'd0);
        reset = 1'b0;
        cycle();

        // Held start request gives exactly one pulse.
        btn_start = 1'b1;
        step("start c1", F_START, 4'd0);
        step("start c2", F_RUN, 4'd0);
        step("start c3", F_RUN, 4'd0);
        btn_start = 1'b0;

        // Inside the gap with horizontal overlap: no hit; above the gap: hit.
        x_left = 10'd290; x_right = 10'd370; bird_y = 10'd150; frame_tick = 1'b1;
        step("in gap", F_RUN, 4'd0);
        bird_y = 10'd90;
        step("above gap", F_HIT, 4'd0);
        frame_tick = 1'b0;
        score = 4'd3;
        hold_to_over("game1", 4'd0, 4'd3);

        // Gap table through the renderer port.
        for (int i = 0; i < 4; i++) begin
            pipe_idx = 2'(i);
            now("gap table", F_OVER, 4'd3);
        end
        pipe_idx = 2'd0;

        // Held ack gives one pulse, then IDLE ignores it.
        btn_ack = 1'b1;
        step("ack c1", F_ACK, 4'd3);
        step("ack c2", F_IDLE, 4'd3);
        step("ack c3", F_IDLE, 4'd3);
        step("ack c4", F_IDLE, 4'd3);
        btn_ack = 1'b0;

        // Tick on the IDLE->RUN edge with a colliding bird is not evaluated.
        x_left = 10'd290; x_right = 10'd370; bird_y = 10'd90;
        btn_start = 1'b1; frame_tick = 1'b1;
        step("tick on start", F_START, 4'd3);
        btn_start = 1'b0; frame_tick = 1'b0;
        step("no eval", F_RUN, 4'd3);

        // No horizontal overlap: outside the gap is safe; floor bound hits.
        x_left = 10'd400; x_right = 10'd480; bird_y = 10'd10; frame_tick = 1'b1;
        step("no overlap", F_RUN, 4'd3);
        bird_y = 10'd459;
        step("floor-1", F_RUN, 4'd3);
        bird_y = 10'd460;
        step("floor", F_HIT, 4'd3);
        frame_tick = 1'b0;
        score = 4'd7;
        hold_to_over("game2", 4'd3, 4'd7);
        btn_ack = 1'b1;
        step("ack g2", F_ACK, 4'd7);
        btn_ack = 1'b0;

        // Game 3: exact gap edges are safe, one past the bottom hits at
        // x_left == BIRD_X_R; lower score leaves high_score alone.
        btn_start = 1'b1;
        step("start g3", F_START, 4'd7);
        btn_start = 1'b0;
        x_left = 10'd320; x_right = 10'd400; bird_y = 10'd100; frame_tick = 1'b1;
        step("gap top edge", F_RUN, 4'd7);
        bird_y = 10'd200;
        step("gap bottom edge", F_RUN, 4'd7);
        bird_y = 10'd201;
        step("below gap", F_HIT, 4'd7);
        frame_tick = 1'b0;
        score = 4'd5;
        hold_to_over("game3", 4'd7, 4'd7);
        btn_ack = 1'b1;
        step("ack g3", F_ACK, 4'd7);
        btn_ack = 1'b0;

        // Game 4: ceiling bound, then asynchronous reset while in HIT.
        btn_start = 1'b1;
        step("start g4", F_START, 4'd7);
        btn_start = 1'b0;
        x_left = 10'd600; x_right = 10'd639; bird_y = 10'd0; frame_tick = 1'b1;
        step("ceiling", F_HIT, 4'd7);
        step("hit hold", F_HIT, 4'd7);
        frame_tick = 1'b0;
        #2;
        reset = 1'b1;
        now("async reset", F_IDLE, 4'd0);
        cycle();
        reset = 1'b0;
        step("after reset", F_IDLE, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
